// File: rtl/exu_div_iter.sv
// Iterative restoring integer divider retiring BPC quotient bits per cycle.
// Handles signed or unsigned operands, returns the quotient or the remainder, and resolves trivial operands early.
module exu_div_iter #(
   parameter int WIDTH = 32,
   parameter int BPC   = 1
) (
   input  logic             clk,
   input  logic             rst_l,
   input  logic             valid_in,
   input  logic             unsign,
   input  logic             rem,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             fast_disable,
   input  logic             flush,
   output logic             ready,
   output logic             stall,
   output logic             finish,
   output logic [WIDTH-1:0] result
);

   localparam int N     = WIDTH / BPC;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_ready;
   logic               r_finish;
   logic [WIDTH-1:0]   r_result;

   logic               r_rem;
   logic               r_neg_q;
   logic               r_neg_r;
   logic               r_dvs_zero;
   logic [WIDTH-1:0]   r_quo;
   logic [WIDTH-1:0]   r_prem;
   logic [WIDTH-1:0]   r_dvs;

   logic               w_dvd_neg;
   logic               w_dvs_neg;
   logic [WIDTH-1:0]   w_dvd_mag;
   logic [WIDTH-1:0]   w_dvs_mag;
   logic               w_dvs_zero;
   logic               w_fast;
   logic               w_start;
   logic [WIDTH-1:0]   w_prem_nx;
   logic [WIDTH-1:0]   w_quo_nx;
   logic [WIDTH:0]     w_shift;
   logic [WIDTH:0]     w_trial;
   logic [WIDTH-1:0]   w_q_fix;
   logic [WIDTH-1:0]   w_r_fix;
   logic [WIDTH-1:0]   w_res;

   assign w_dvd_neg  = ~unsign & dividend[WIDTH-1];
   assign w_dvs_neg  = ~unsign & divisor[WIDTH-1];
   assign w_dvd_mag  = w_dvd_neg ? -dividend : dividend;
   assign w_dvs_mag  = w_dvs_neg ? -divisor : divisor;
   assign w_dvs_zero = (divisor == '0);
   assign w_fast     = ~fast_disable & (w_dvs_zero | (w_dvd_mag < w_dvs_mag));
   assign w_start    = (r_state == S_IDLE) & valid_in & ~flush;

   // Dividend bits shift out of r_quo's MSB while quotient bits shift into its LSB
   always_comb begin
      w_prem_nx = r_prem;
      w_quo_nx  = r_quo;
      w_shift   = '0;
      w_trial   = '0;
      for (int k = 0; k < BPC; k++) begin
         w_shift   = {w_prem_nx, w_quo_nx[WIDTH-1]};
         w_trial   = w_shift - {1'b0, r_dvs};
         w_prem_nx = w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
         w_quo_nx  = {w_quo_nx[WIDTH-2:0], ~w_trial[WIDTH]};
      end
   end

   assign w_q_fix = r_dvs_zero ? '1 : (r_neg_q ? -r_quo : r_quo);
   assign w_r_fix = r_neg_r ? -r_prem : r_prem;
   assign w_res   = r_rem ? w_r_fix : w_q_fix;

   always_ff @(posedge clk) begin
      if (w_start) begin
         r_rem      <= rem;
         r_neg_q    <= w_dvd_neg ^ w_dvs_neg;
         r_neg_r    <= w_dvd_neg;
         r_dvs_zero <= w_dvs_zero;
         r_dvs      <= w_dvs_mag;
         r_quo      <= w_fast ? '0 : w_dvd_mag;
         r_prem     <= w_fast ? w_dvd_mag : '0;
      end else if (r_state == S_RUN) begin
         r_quo      <= w_quo_nx;
         r_prem     <= w_prem_nx;
      end
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_ready  <= 1'b1;
         r_finish <= 1'b0;
         r_result <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_ready <= 1'b0;
                  r_cnt   <= '0;
                  r_state <= w_fast ? S_FIX : S_RUN;
               end
            end
            S_RUN: begin
               if (flush) begin
                  r_state <= S_IDLE;
                  r_ready <= 1'b1;
                  r_cnt   <= '0;
               end else if (r_cnt == CNT_W'(N - 1)) begin
                  r_state <= S_FIX;
                  r_cnt   <= '0;
               end else begin
                  r_cnt   <= r_cnt + 1'b1;
               end
            end
            S_FIX: begin
               if (flush) begin
                  r_state  <= S_IDLE;
                  r_ready  <= 1'b1;
               end else begin
                  r_result <= w_res;
                  r_finish <= 1'b1;
                  r_state  <= S_DONE;
               end
            end
            S_DONE: begin
               r_finish <= 1'b0;
               r_ready  <= 1'b1;
               r_state  <= S_IDLE;
            end
            default: begin
               r_state  <= S_IDLE;
               r_ready  <= 1'b1;
               r_finish <= 1'b0;
            end
         endcase
      end
   end

   assign ready  = r_ready;
   assign stall  = ~r_ready;
   assign finish = r_finish;
   assign result = r_result;

endmodule

// File: tb/tb_exu_div_iter.sv
// Bench for exu_div_iter: three dividers (BPC 1, 2, 4) share one stimulus stream
// and are compared against an arithmetic reference for result and latency.
module tb_exu_div_iter;

   logic        clk = 1'b0;
   logic        rst_l;
   logic        valid_in;
   logic        unsign;
   logic        rem;
   logic        fast_disable;
   logic        flush;
   logic [31:0] dividend;
   logic [31:0] divisor;

   logic        rdy [3];
   logic        stl [3];
   logic        fin [3];
   logic [31:0] res [3];

   logic [31:0] exp_last [3];
   int          vectors     = 0;
   int          miscompares = 0;

   always #5 clk = ~clk;

   exu_div_iter #(.WIDTH(32), .BPC(1)) u_div1 (
      .clk(clk), .rst_l(rst_l), .valid_in(valid_in), .unsign(unsign), .rem(rem),
      .dividend(dividend), .divisor(divisor), .fast_disable(fast_disable), .flush(flush),
      .ready(rdy[0]), .stall(stl[0]), .finish(fin[0]), .result(res[0]));

   exu_div_iter #(.WIDTH(32), .BPC(2)) u_div2 (
      .clk(clk), .rst_l(rst_l), .valid_in(valid_in), .unsign(unsign), .rem(rem),
      .dividend(dividend), .divisor(divisor), .fast_disable(fast_disable), .flush(flush),
      .ready(rdy[1]), .stall(stl[1]), .finish(fin[1]), .result(res[1]));

   exu_div_iter #(.WIDTH(32), .BPC(4)) u_div4 (
      .clk(clk), .rst_l(rst_l), .valid_in(valid_in), .unsign(unsign), .rem(rem),
      .dividend(dividend), .divisor(divisor), .fast_disable(fast_disable), .flush(flush),
      .ready(rdy[2]), .stall(stl[2]), .finish(fin[2]), .result(res[2]));

   task automatic check(input string tag, input int inst, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s[bpc%0d] observed=%0h expected=%0h", tag, 1 << inst, obs, exp);
      end
   endtask

   function automatic longint to_val(input logic [31:0] x, input logic uns);
      return uns ? longint'({32'b0, x}) : longint'($signed(x));
   endfunction

   // Truncating division; divide-by-zero yields all ones and the dividend
   function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                           input logic uns, input logic rm);
      longint sa, sb, q, r;
      sa = to_val(a, uns);
      sb = to_val(b, uns);
      if (b == 32'd0) begin
         q = -1;
         r = sa;
      end else begin
         q = sa / sb;
         r = sa % sb;
      end
      return rm ? r[31:0] : q[31:0];
   endfunction

   function automatic bit ref_fast(input logic [31:0] a, input logic [31:0] b,
                                   input logic uns, input logic fd);
      longint ma, mb;
      ma = to_val(a, uns);
      mb = to_val(b, uns);
      if (ma < 0) ma = -ma;
      if (mb < 0) mb = -mb;
      return !fd && (b == 32'd0 || ma < mb);
   endfunction

   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         input logic uns, input logic rm, input logic fd);
      logic [31:0] exp_res;
      int          expc [3];
      int          fc   [3];
      int          bad  [3];
      logic [31:0] got  [3];
      logic        exp_busy;
      exp_res = ref_div(a, b, uns, rm);
      for (int i = 0; i < 3; i++) begin
         expc[i] = ref_fast(a, b, uns, fd) ? 2 : (32 >> i) + 2;
         fc[i]   = 0;
         bad[i]  = 0;
         got[i]  = 'x;
      end
      dividend = a; divisor = b; unsign = uns; rem = rm; fast_disable = fd;
      valid_in = 1'b1;
      for (int c = 1; c <= 35; c++) begin
         @(negedge clk);
         if (c == 1) valid_in = 1'b0;
         for (int i = 0; i < 3; i++) begin
            exp_busy = (c <= expc[i]);
            if (fin[i] === 1'b1 && fc[i] == 0) begin
               fc[i]  = c;
               got[i] = res[i];
            end
            if (stl[i] !== exp_busy || rdy[i] !== !exp_busy) bad[i]++;
            if (fin[i] !== (c == expc[i])) bad[i]++;
            if (c < expc[i] && res[i] !== exp_last[i]) bad[i]++;
         end
      end
      for (int i = 0; i < 3; i++) begin
         check("latency", i, 64'(fc[i]), 64'(expc[i]));
         check("result", i, {32'b0, got[i]}, {32'b0, exp_res});
         check("handshake", i, 64'(bad[i]), 64'd0);
         exp_last[i] = exp_res;
      end
   endtask

   // 0x100/2 flushed in cycle 10; a stray request in cycle 5 must be ignored
   task automatic flush_op();
      int fcnt [3];
      for (int i = 0; i < 3; i++) fcnt[i] = 0;
      dividend = 32'h100; divisor = 32'h2; unsign = 1'b1; rem = 1'b0; fast_disable = 1'b1;
      valid_in = 1'b1;
      for (int c = 1; c <= 11; c++) begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) if (fin[i] === 1'b1) fcnt[i]++;
         if (c == 1) valid_in = 1'b0;
         if (c == 5) begin valid_in = 1'b1; dividend = 32'h7; divisor = 32'h1; end
         if (c == 6) valid_in = 1'b0;
         if (c == 10) begin
            check("bpc4_fin_c10", 2, {63'b0, fin[2]}, 64'd1);
            flush = 1'b1;
         end
         if (c == 11) flush = 1'b0;
      end
      exp_last[2] = 32'h80;
      for (int i = 0; i < 3; i++) begin
         check("flush_ready", i, {63'b0, rdy[i]}, 64'd1);
         check("flush_fincnt", i, 64'(fcnt[i]), (i == 2) ? 64'd1 : 64'd0);
         check("flush_hold", i, {32'b0, res[i]}, {32'b0, exp_last[i]});
      end
   endtask

   task automatic reset_mid_op();
      int fcnt;
      fcnt = 0;
      dividend = 32'h100; divisor = 32'h2; unsign = 1'b1; rem = 1'b0; fast_disable = 1'b1;
      valid_in = 1'b1;
      @(negedge clk);
      valid_in = 1'b0;
      repeat (3) @(negedge clk);
      rst_l = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         check("arst_ready", i, {63'b0, rdy[i]}, 64'd1);
         check("arst_stall", i, {63'b0, stl[i]}, 64'd0);
         check("arst_result", i, {32'b0, res[i]}, 64'd0);
         exp_last[i] = 32'd0;
      end
      @(negedge clk);
      rst_l = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) if (fin[i] !== 1'b0) fcnt++;
      end
      check("arst_nofinish", 0, 64'(fcnt), 64'd0);
   endtask

   initial begin
      logic [31:0] a, b;
      int          mode;
      rst_l = 1'b0; valid_in = 1'b0; unsign = 1'b0; rem = 1'b0; fast_disable = 1'b0;
      flush = 1'b0; dividend = '0; divisor = '0;
      for (int i = 0; i < 3; i++) exp_last[i] = 32'd0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check("rst_ready", i, {63'b0, rdy[i]}, 64'd1);
         check("rst_stall", i, {63'b0, stl[i]}, 64'd0);
         check("rst_finish", i, {63'b0, fin[i]}, 64'd0);
         check("rst_result", i, {32'b0, res[i]}, 64'd0);
      end
      rst_l = 1'b1;
      @(negedge clk);

      run_op(32'h100, 32'h2, 1'b1, 1'b0, 1'b1);
      run_op(-32'sd7, 32'h2, 1'b0, 1'b0, 1'b1);
      run_op(-32'sd7, 32'h2, 1'b0, 1'b1, 1'b1);
      run_op(32'h1234, 32'h0, 1'b1, 1'b0, 1'b0);
      run_op(32'h1234, 32'h0, 1'b1, 1'b1, 1'b0);
      run_op(32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1);
      run_op(32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b1);
      run_op(32'h5, 32'h9, 1'b1, 1'b0, 1'b0);
      run_op(32'h5, 32'h9, 1'b1, 1'b0, 1'b1);
      run_op(-32'sd5, 32'h0, 1'b0, 1'b0, 1'b1);
      run_op(-32'sd5, 32'h0, 1'b0, 1'b1, 1'b1);

      flush_op();
      run_op(32'h100, 32'h2, 1'b1, 1'b0, 1'b1);
      reset_mid_op();

      for (int n = 0; n < 40; n++) begin
         mode = int'($urandom_range(0, 5));
         a = $urandom;
         b = $urandom;
         case (mode)
            1: begin a = $urandom_range(0, 40); b = $urandom_range(1, 12); end
            2: b = 32'd0;
            3: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            4: b = $urandom_range(1, 300) ^ {32{b[31]}};
            5: a = $urandom_range(0, 300) ^ {32{a[31]}};
            default: ;
         endcase
         run_op(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
